// File: rtl/mem_unit.sv
`timescale 1ns/1ps
// mem_unit: load/store unit between a unit-select request bus and a
// single-cycle-latency word RAM. Handles byte/half/word widths, lane
// placement for stores, sign/zero extension for loads and alignment faults.

package mem_unit_pkg;
    typedef logic [31:0] word_t;
    typedef word_t [2:0] unit_in_t;

    typedef enum logic [1:0] {
        UNIT_SEL_NONE = 2'd0,
        UNIT_SEL_ALU  = 2'd1,
        UNIT_SEL_MEM  = 2'd2,
        UNIT_SEL_CSR  = 2'd3
    } unit_sel_t;

    localparam logic [3:0] MEM_CTRL_READ  = 4'b0010;
    localparam logic [3:0] MEM_CTRL_WRITE = 4'b1010;
endpackage

module mem_unit
    import mem_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  unit_sel_t   unit_sel,
    input  unit_in_t    unit_in,
    output word_t       unit_out,
    output logic        unit_ready,
    output logic        fault,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  ctrl_q;
    logic [1:0]  alo_q;
    logic        fault_q;
    word_t       out_q;

    logic        req_wr;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_take;
    logic        req_misalign;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [31:0] rd_shift;
    word_t       load_val;
    logic        unused_ctrl_bits;

    assign req_wr           = unit_in[0][3];
    assign req_f3           = unit_in[0][2:0];
    assign req_addr         = unit_in[1];
    assign req_data         = unit_in[2];
    assign unused_ctrl_bits = ^unit_in[0][31:4];

    assign req_take = (state_q == IDLE) && (unit_sel == UNIT_SEL_MEM);

    // Alignment check by access width; reserved width codes always fault
    always_comb begin
        req_misalign = 1'b1;
        case (req_f3)
            3'b000, 3'b100: req_misalign = 1'b0;
            3'b001, 3'b101: req_misalign = req_addr[0];
            3'b010:         req_misalign = |req_addr[1:0];
            default:        req_misalign = 1'b1;
        endcase
    end

    // Store data replication and byte-lane enables
    always_comb begin
        lane_we    = 4'b1111;
        lane_wdata = req_data;
        case (req_f3[1:0])
            2'b00: begin
                lane_we    = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_data[7:0]}};
            end
            2'b01: begin
                lane_we    = 4'b0011 << req_addr[1:0];
                lane_wdata = {2{req_data[15:0]}};
            end
            default: begin
                lane_we    = 4'b1111;
                lane_wdata = req_data;
            end
        endcase
    end

    // RAM strobe is combinational so read data lands in WAIT; gated by reset
    assign ram_en    = rst_n && req_take && !req_misalign;
    assign ram_we    = (ram_en && req_wr) ? lane_we : '0;
    assign ram_addr  = req_addr[31:2];
    assign ram_wdata = lane_wdata;

    // Load extraction from the captured width code and byte offset
    always_comb begin
        rd_shift = ram_rdata >> {alo_q, 3'b000};
        load_val = '0;
        if (!ctrl_q[3]) begin
            case (ctrl_q[2:0])
                3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
                3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
                3'b010:  load_val = ram_rdata;
                3'b100:  load_val = {24'd0, rd_shift[7:0]};
                3'b101:  load_val = {16'd0, rd_shift[15:0]};
                default: load_val = '0;
            endcase
        end
    end

    assign unit_ready = (state_q == RESP) ||
                        ((state_q == IDLE) && (unit_sel != UNIT_SEL_MEM));
    assign unit_out   = out_q;
    assign fault      = fault_q;

    // Request FSM; out_q/fault_q are only non-zero while in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            alo_q   <= '0;
            fault_q <= 1'b0;
            out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_take) begin
                        ctrl_q <= unit_in[0][3:0];
                        alo_q  <= req_addr[1:0];
                        if (req_misalign) begin
                            fault_q <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    out_q   <= load_val;
                    state_q <= RESP;
                end
                RESP: begin
                    out_q   <= '0;
                    fault_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
